point_gen: RTL
==============

POINT_GEN -- requirements
Module: point_gen

Interface
REQ-001 SHALL have parameter MIN_OVERLAP, default 4: overlapping ball/target pixels per frame needed to score (1..65535).
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 30: frames ignored after a point (0..255).
REQ-003 SHALL have clk148  input  1  pixel clock, 148.5 MHz; all logic rising-edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have game_en  input  1  level; 0 forces IDLE.
REQ-006 SHALL have frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-007 SHALL have ball_px  input  1  current pixel belongs to ball.
REQ-008 SHALL have target_px  input  1  current pixel belongs to target.
REQ-009 SHALL have point  output  1  one-cycle score pulse, feeds score counter increment.
REQ-010 SHALL have busy  output  1  high while in COOLDOWN.
REQ-011 SHALL have hit_cnt  output  16  total points issued (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, ARMED, FIRE, COOLDOWN; state, counters and outputs registered.
REQ-013 IDLE: when game_en=1 -> ARMED next cycle with ov_cnt=0.
REQ-014 ARMED: ov_cnt (16 bit, saturating at 65535) SHALL increment each cycle where ball_px&target_px=1 and frame_start=0; overlap on a frame_start cycle is ignored.
REQ-015 ARMED on frame_start: if ov_cnt>=MIN_OVERLAP -> FIRE, else stay ARMED; ov_cnt cleared to 0 in both cases.
REQ-016 point SHALL equal 1 exactly while state=FIRE: one cycle, asserted the cycle after the qualifying frame_start.
REQ-017 FIRE SHALL last one cycle: -> COOLDOWN with cd_cnt=COOLDOWN_FRAMES, or -> ARMED directly if COOLDOWN_FRAMES=0.
REQ-018 COOLDOWN: each frame_start decrements cd_cnt; frame_start with cd_cnt=1 -> ARMED with ov_cnt=0; overlap pixels not counted.
REQ-019 busy SHALL be 1 exactly while state=COOLDOWN.
REQ-020 game_en=0 in any state SHALL force IDLE next cycle and clear ov_cnt and cd_cnt; game_en takes priority over frame_start in the same cycle.
REQ-021 A point already asserted in FIRE SHALL NOT be extended or repeated when game_en falls in that cycle.
REQ-022 At most one point pulse per frame; frame_start arriving while in FIRE SHALL be treated as a COOLDOWN decrement only if COOLDOWN was entered (i.e. ignored in FIRE).

Reset
REQ-023 rst_n=1 SHALL immediately force state=IDLE, ov_cnt=0, cd_cnt=0, point=0, busy=0, hit_cnt=0, independent of clk148.
REQ-024 Reset mid-frame or mid-cooldown SHALL discard partial overlap and remaining cooldown; after release, operation restarts from IDLE.

Configuration
REQ-025 Macro POINT_GEN_HITCNT_EN: when defined, hit_cnt SHALL increment by 1 in every FIRE cycle, saturating at 65535, cleared only by reset.
REQ-026 Without POINT_GEN_HITCNT_EN, hit_cnt SHALL be constant 0 and no counter logic SHALL be synthesized; all other behaviour unchanged.

Verification (MIN_OVERLAP=4, COOLDOWN_FRAMES=2)
REQ-027 game_en=1, 5 overlap cycles, then frame_start -> point=1 for exactly one cycle, one cycle after frame_start; busy=1 next cycle.
REQ-028 game_en=1, 3 overlap cycles, frame_start -> no point; next frame 4 overlap cycles, frame_start -> one point.
REQ-029 After a point, 10 overlap cycles in each of next 2 frames -> no point, busy falls on 2nd frame_start; 3rd frame with 4 overlaps -> point.
REQ-030 Overlap asserted only on frame_start cycles (4 frames) -> no point, ov_cnt stays 0.
REQ-031 game_en dropped in COOLDOWN with cd_cnt=2, re-raised, 4 overlaps, frame_start -> point (cooldown discarded); rst_n pulse mid-frame after 3 overlaps -> all outputs 0 immediately, no point at next frame_start.
REQ-032 With POINT_GEN_HITCNT_EN, 3 points issued -> hit_cnt=3; without macro -> hit_cnt=0 throughout.

Source files
------------

// File: rtl/point_gen.sv
// point_gen -- scores a point when the ball overlaps the target for enough
// pixels within one video frame, then holds off scoring for a number of
// frames.
//
// Optional feature: define POINT_GEN_HITCNT_EN to build the running
// point counter on hit_cnt; otherwise hit_cnt is tied to zero.
//
// Parameters
//   MIN_OVERLAP      overlapping ball/target pixels per frame needed to score
//   COOLDOWN_FRAMES  frames ignored after a point (0 = no cooldown)
//
// Ports
//   clk148       in   pixel clock, all logic on the rising edge
//   rst_n        in   asynchronous reset, active-high (legacy name)
//   game_en      in   level, 0 forces IDLE
//   frame_start  in   one-cycle pulse at start of vertical blanking
//   ball_px      in   current pixel belongs to the ball
//   target_px    in   current pixel belongs to the target
//   point        out  one-cycle score pulse (high exactly in FIRE)
//   busy         out  high exactly in COOLDOWN
//   hit_cnt      out  total points issued (0 unless POINT_GEN_HITCNT_EN)
module point_gen #(
  parameter int MIN_OVERLAP     = 4,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic        clk148,
  input  logic        rst_n,
  input  logic        game_en,
  input  logic        frame_start,
  input  logic        ball_px,
  input  logic        target_px,
  output logic        point,
  output logic        busy,
  output logic [15:0] hit_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    FIRE     = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [15:0] MIN_OV  = 16'(MIN_OVERLAP);
  localparam logic [7:0]  CD_LOAD = 8'(COOLDOWN_FRAMES);

  state_t      state_q, state_d;
  logic [15:0] ov_cnt_q, ov_cnt_d;
  logic [7:0]  cd_cnt_q, cd_cnt_d;
  logic        point_q, point_d;
  logic        busy_q, busy_d;

  logic overlap;
  assign overlap = ball_px & target_px;

  always_comb begin
    state_d  = state_q;
    ov_cnt_d = ov_cnt_q;
    cd_cnt_d = cd_cnt_q;

    if (!game_en) begin
      // Dropping the game enable wins over everything, including a
      // frame_start in the same cycle, and discards partial progress.
      state_d  = IDLE;
      ov_cnt_d = '0;
      cd_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = ARMED;
          ov_cnt_d = '0;
        end
        ARMED: begin
          if (frame_start) begin
            // Overlap on the frame_start cycle itself belongs to no frame.
            ov_cnt_d = '0;
            if (ov_cnt_q >= MIN_OV) state_d = FIRE;
          end else if (overlap && (ov_cnt_q != 16'hFFFF)) begin
            ov_cnt_d = ov_cnt_q + 16'd1;
          end
        end
        FIRE: begin
          // A frame_start seen here is deliberately ignored.
          if (COOLDOWN_FRAMES == 0) begin
            state_d  = ARMED;
            ov_cnt_d = '0;
          end else begin
            state_d  = COOLDOWN;
            cd_cnt_d = CD_LOAD;
          end
        end
        COOLDOWN: begin
          if (frame_start) begin
            if (cd_cnt_q <= 8'd1) begin
              state_d  = ARMED;
              ov_cnt_d = '0;
              cd_cnt_d = '0;
            end else begin
              cd_cnt_d = cd_cnt_q - 8'd1;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          ov_cnt_d = '0;
          cd_cnt_d = '0;
        end
      endcase
    end

    // Outputs are registered copies of the next state so they line up
    // exactly with the state register.
    point_d = (state_d == FIRE);
    busy_d  = (state_d == COOLDOWN);
  end

`ifdef POINT_GEN_HITCNT_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if ((state_q == FIRE) && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
  end

  always_ff @(posedge clk148 or posedge rst_n) begin
    if (rst_n) hit_cnt_q <= '0;
    else       hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt = hit_cnt_q;
`else
  assign hit_cnt = 16'd0;
`endif

  // rst_n is active-high despite its name.
  always_ff @(posedge clk148 or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= IDLE;
      ov_cnt_q <= '0;
      cd_cnt_q <= '0;
      point_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ov_cnt_q <= ov_cnt_d;
      cd_cnt_q <= cd_cnt_d;
      point_q  <= point_d;
      busy_q   <= busy_d;
    end
  end

  assign point = point_q;
  assign busy  = busy_q;

endmodule
